// File: rtl/priority_codec_pkg.sv
// Shared definitions for the priority encoder/decoder pair: default widths, code
// format and decoder FSM states.
package priority_codec_pkg;

  localparam int unsigned NLinesDefault = 8;
  localparam int unsigned IdxWDefault   = 3;

  typedef struct packed {
    logic                   none;
    logic [IdxWDefault-1:0] idx;
  } code_t;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StGap
  } state_e;

endpackage

// File: rtl/code_fifo.sv
// Small synchronous FIFO holding encoded codes; exposes fill count and head entry.
module code_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           head_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned FillW = $clog2(Depth + 1);
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [FillW-1:0] count_q;
  logic             do_push, do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
  endfunction

  assign do_push = push_i && (count_q != FillW'(Depth));
  assign do_pop  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + FillW'(1);
        2'b01:   count_q <= count_q - FillW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/priority_decoder.sv
// Receives {none, idx} codes, queues them and replays each as a held one-hot pulse
// followed by a single idle gap cycle.
module priority_decoder
  import priority_codec_pkg::*;
#(
  parameter int unsigned N_LINES     = NLinesDefault,
  parameter int unsigned IDX_W       = IdxWDefault,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IDX_W-1:0]   in_idx,
  input  logic               in_none,
  output logic [N_LINES-1:0] out_onehot,
  output logic               out_valid,
  output logic               busy,
  output logic               err
);

  localparam int unsigned CodeW = IDX_W + 1;
  localparam int unsigned FillW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CntW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0]  HoldLoad  = CntW'(HOLD_CYCLES - 1);
  localparam logic [IDX_W:0]   NLinesExt = (IDX_W + 1)'(N_LINES);

  logic [FillW-1:0]   count;
  logic [CodeW-1:0]   head;
  logic [CodeW-1:0]   push_data;
  logic               push, pop;
  logic               head_none;
  logic [IDX_W-1:0]   head_idx;
  logic               head_in_range;
  logic [N_LINES-1:0] decoded;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [N_LINES-1:0] onehot_q, onehot_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  // Ready depends only on reset and the registered fill level.
  assign in_ready  = !rst && (count != FillW'(FIFO_DEPTH));
  assign push      = in_valid && in_ready;
  assign push_data = {in_none, in_idx};

  code_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (CodeW)
  ) u_code_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign {head_none, head_idx} = head;
  // Zero-extend by one bit so N_LINES == 2**IDX_W stays representable.
  assign head_in_range = {1'b0, head_idx} < NLinesExt;
  assign decoded = (head_none || !head_in_range) ? '0 : (N_LINES'(1) << head_idx);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    err_d    = err_q;
    pop      = 1'b0;
    unique case (state_q)
      StIdle, StGap: begin
        state_d  = StIdle;
        onehot_d = '0;
        valid_d  = 1'b0;
        if (count != '0) begin
          pop      = 1'b1;
          state_d  = StHold;
          cnt_d    = HoldLoad;
          onehot_d = decoded;
          valid_d  = 1'b1;
          if (!head_none && !head_in_range) err_d = 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d  = StGap;
          onehot_d = '0;
          valid_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d  = StIdle;
        onehot_d = '0;
        valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign out_onehot = onehot_q;
  assign out_valid  = valid_q;
  assign err        = err_q;
  assign busy       = (state_q != StIdle) || (count != '0);

endmodule

// File: tb/tb_priority_decoder.sv
// Directed bench for priority_decoder: default configuration plus a 6-line instance
// exercising the out-of-range error path.
module tb_priority_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_none, in_ready;
  logic [2:0] in_idx;
  logic [7:0] out_onehot;
  logic       out_valid, busy, err;

  logic       in6_valid, in6_none, in6_ready;
  logic [2:0] in6_idx;
  logic [5:0] out6_onehot;
  logic       out6_valid, busy6, err6;

  int total = 0;
  int bad   = 0;
  logic [7:0] pat [4];
  logic [2:0] codes [4];
  int k;

  priority_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .in_none    (in_none),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .busy       (busy),
    .err        (err)
  );

  priority_decoder #(
    .N_LINES (6),
    .IDX_W   (3)
  ) dut6 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in6_valid),
    .in_ready   (in6_ready),
    .in_idx     (in6_idx),
    .in_none    (in6_none),
    .out_onehot (out6_onehot),
    .out_valid  (out6_valid),
    .busy       (busy6),
    .err        (err6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse train of k codes starting at cycle s: 4 held cycles then 1 gap cycle each.
  task automatic chk_train(input string tag, input int c, input int s, input int n);
    int rel;
    logic       ev;
    logic [7:0] eo;
    rel = c - s;
    ev  = 1'b0;
    eo  = 8'h00;
    if (rel >= 0 && rel < 5 * n && (rel % 5) < 4) begin
      ev = 1'b1;
      eo = pat[rel / 5];
    end
    chk($sformatf("%s_c%0d_valid", tag, c), {31'b0, out_valid}, {31'b0, ev});
    chk($sformatf("%s_c%0d_onehot", tag, c), {24'b0, out_onehot}, {24'b0, eo});
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_none = 1'b0; in_idx = '0;
    in6_valid = 1'b0; in6_none = 1'b0; in6_idx = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_onehot", {24'b0, out_onehot}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_ready6", {31'b0, in6_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, in_ready}, 32'd1);
    tick();

    // 1: single code idx=5
    pat[0] = 8'h20;
    for (int c = 0; c <= 8; c++) begin
      in_valid = (c == 0);
      in_idx   = 3'd5;
      chk_train("t1", c, 2, 1);
      chk($sformatf("t1_c%0d_busy", c), {31'b0, busy}, (c >= 1 && c <= 6) ? 32'd1 : 32'd0);
      tick();
    end

    // 2: back-to-back 0,7,3
    pat[0] = 8'h01; pat[1] = 8'h80; pat[2] = 8'h08;
    for (int c = 0; c <= 18; c++) begin
      in_valid = (c < 3);
      in_idx   = (c == 0) ? 3'd0 : (c == 1) ? 3'd7 : 3'd3;
      if (c < 3) chk($sformatf("t2_c%0d_ready", c), {31'b0, in_ready}, 32'd1);
      chk_train("t2", c, 2, 3);
      tick();
    end
    chk("t2_busy_end", {31'b0, busy}, 32'd0);

    // 3: none code
    pat[0] = 8'h00;
    for (int c = 0; c <= 7; c++) begin
      in_valid = (c == 0);
      in_none  = (c == 0);
      in_idx   = 3'd3;
      chk_train("t3", c, 2, 1);
      tick();
    end
    chk("t3_err", {31'b0, err}, 32'd0);

    // 4: backpressure with in_valid held high
    codes[0] = 3'd1; codes[1] = 3'd2; codes[2] = 3'd4; codes[3] = 3'd6;
    pat[0] = 8'h02; pat[1] = 8'h04; pat[2] = 8'h10; pat[3] = 8'h40;
    k = 0;
    for (int c = 0; c <= 22; c++) begin
      in_valid = (k < 4);
      in_idx   = (k < 4) ? codes[k] : 3'd0;
      chk($sformatf("t4_c%0d_ready", c), {31'b0, in_ready},
          ((c >= 3 && c <= 6) || (c >= 8 && c <= 11)) ? 32'd0 : 32'd1);
      chk_train("t4", c, 2, 4);
      if (in_valid && in_ready) k++;
      tick();
    end
    in_valid = 1'b0;
    chk("t4_accepted", k, 32'd4);
    chk("t4_busy_end", {31'b0, busy}, 32'd0);

    // 5: reset on 3rd pulse cycle with two entries queued
    pat[0] = 8'h02;
    for (int c = 0; c <= 4; c++) begin
      in_valid = (c < 3);
      in_idx   = (c == 0) ? 3'd1 : (c == 1) ? 3'd2 : 3'd4;
      if (c == 4) begin
        rst = 1'b1;
        #1;
        chk("t5_ready_in_rst", {31'b0, in_ready}, 32'd0);
      end
      chk_train("t5", c, 2, 1);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("t5_after_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_after_onehot", {24'b0, out_onehot}, 32'd0);
    chk("t5_after_busy", {31'b0, busy}, 32'd0);
    chk("t5_after_ready", {31'b0, in_ready}, 32'd1);
    tick();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("t5_quiet_c%0d_valid", c), {31'b0, out_valid}, 32'd0);
      chk($sformatf("t5_quiet_c%0d_onehot", c), {24'b0, out_onehot}, 32'd0);
      tick();
    end

    // 6: N_LINES=6, out-of-range idx=6 then idx=2
    for (int c = 0; c <= 7; c++) begin
      in6_valid = (c == 0);
      in6_idx   = 3'd6;
      chk($sformatf("t6a_c%0d_valid", c), {31'b0, out6_valid},
          (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
      chk($sformatf("t6a_c%0d_onehot", c), {26'b0, out6_onehot}, 32'd0);
      chk($sformatf("t6a_c%0d_err", c), {31'b0, err6}, (c >= 2) ? 32'd1 : 32'd0);
      tick();
    end
    for (int c = 0; c <= 7; c++) begin
      in6_valid = (c == 0);
      in6_idx   = 3'd2;
      chk($sformatf("t6b_c%0d_valid", c), {31'b0, out6_valid},
          (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
      chk($sformatf("t6b_c%0d_onehot", c), {26'b0, out6_onehot},
          (c >= 2 && c <= 5) ? 32'h04 : 32'd0);
      chk($sformatf("t6b_c%0d_err", c), {31'b0, err6}, 32'd1);
      tick();
    end
    chk("t6_main_err", {31'b0, err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
